// File: rtl/usb_tx_line_driver_pkg.sv
// Shared types and constants for the USB transmit line driver:
// line-state encodings, FSM states and end-of-packet timing.
package usb_tx_line_driver_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        EOP_SE0,
        EOP_J
    } tx_state_e;

    // Line state packed as {dPlus, dMinus}
    typedef logic [1:0] line_t;

    localparam line_t LINE_SE0     = 2'b00;
    localparam int    EOP_SE0_BITS = 2;
    localparam int    EOP_J_BITS   = 1;

    function automatic line_t line_j(input bit low_speed);
        return low_speed ? 2'b01 : 2'b10;
    endfunction

    function automatic line_t line_k(input bit low_speed);
        return low_speed ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/usb_tx_line_driver_stuffer.sv
// Bit stuffer: counts consecutive 1s and flags the strobe on which a stuff
// bit has to be inserted instead of consuming the source bit.
module usb_bit_stuffer #(
    parameter int STUFF_LIMIT = 6
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic strobe_i,
    input  logic in_data_i,
    input  logic bit_valid_i,
    input  logic tx_bit_i,
    input  logic clear_i,
    output logic stall_o
);

    localparam int                CNT_W = $clog2(STUFF_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STUFF_LIMIT);

    logic [CNT_W-1:0] ones_q, ones_d;

    assign stall_o = in_data_i && (ones_q == LIMIT);

    always_comb begin
        // NOTE: default first so every path assigns ones_d and no latch is inferred.
        ones_d = ones_q;
        if (strobe_i) begin
            if (stall_o || clear_i) begin
                ones_d = '0;
            end else if (bit_valid_i) begin
                ones_d = tx_bit_i ? ones_q + 1'b1 : '0;
            end
        end
    end

    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/usb_tx_line_driver.sv
// USB transmit line driver: NRZI encoding with bit stuffing, SE0/J
// end-of-packet signalling and transceiver output-enable control.
module usb_tx_line_driver
    import usb_tx_line_driver_pkg::*;
#(
    parameter bit LOW_SPEED   = 1'b0,
    parameter int STUFF_LIMIT = 6
) (
    input  logic useClk,
    input  logic rst,
    input  logic checkData,
    input  logic txEnable,
    input  logic txBit,
    input  logic callEop,
    output logic txStall,
    output logic dPlus,
    output logic dMinus,
    output logic OE_USB,
    output logic txBusy,
    output logic txDone
);

    localparam line_t LINE_J = line_j(LOW_SPEED);
    localparam line_t LINE_K = line_k(LOW_SPEED);

    tx_state_e   state_q, state_d;
    line_t       line_q, line_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [1:0]  eop_cnt_q, eop_cnt_d;
    logic        eop_pending_q, eop_pending_d;

    logic        in_data;
    logic        start;
    logic        eop_req;
    logic        bit_valid;
    logic        clear;
    line_t       line_toggled;

    assign in_data      = (state_q == DATA);
    assign eop_req      = callEop || !txEnable;
    assign start        = (state_q == IDLE) && txEnable && !callEop;
    assign bit_valid    = start || (in_data && !txStall && !eop_pending_q && !eop_req);
    assign clear        = !in_data && !start;
    // Line is always J or K in DATA, so toggling is a plain J<->K swap
    assign line_toggled = (line_q == LINE_J) ? LINE_K : LINE_J;

    usb_bit_stuffer #(
        .STUFF_LIMIT (STUFF_LIMIT)
    ) u_stuffer (
        .clk_i       (useClk),
        .rst_i       (rst),
        .strobe_i    (checkData),
        .in_data_i   (in_data),
        .bit_valid_i (bit_valid),
        .tx_bit_i    (txBit),
        .clear_i     (clear),
        .stall_o     (txStall)
    );

    always_comb begin
        state_d       = state_q;
        line_d        = line_q;
        oe_d          = oe_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        eop_cnt_d     = eop_cnt_q;
        eop_pending_d = eop_pending_q;
        if (checkData) begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = DATA;
                        oe_d    = 1'b1;
                        busy_d  = 1'b1;
                        line_d  = txBit ? LINE_J : LINE_K;
                    end
                end
                DATA: begin
                    if (txStall) begin
                        line_d = line_toggled;
                        if (eop_req) eop_pending_d = 1'b1;
                    end else if (eop_pending_q || eop_req) begin
                        state_d       = EOP_SE0;
                        line_d        = LINE_SE0;
                        eop_cnt_d     = 2'd1;
                        eop_pending_d = 1'b0;
                    end else if (!txBit) begin
                        line_d = line_toggled;
                    end
                end
                EOP_SE0: begin
                    if (eop_cnt_q == 2'(EOP_SE0_BITS)) begin
                        state_d   = EOP_J;
                        line_d    = LINE_J;
                        eop_cnt_d = 2'd1;
                    end else begin
                        eop_cnt_d = eop_cnt_q + 2'd1;
                    end
                end
                EOP_J: begin
                    if (eop_cnt_q == 2'(EOP_J_BITS)) begin
                        state_d   = IDLE;
                        line_d    = LINE_J;
                        oe_d      = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        eop_cnt_d = 2'd0;
                    end else begin
                        eop_cnt_d = eop_cnt_q + 2'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge useClk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            line_q        <= LINE_J;
            oe_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            eop_cnt_q     <= 2'd0;
            eop_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_q        <= line_d;
            oe_q          <= oe_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            eop_cnt_q     <= eop_cnt_d;
            eop_pending_q <= eop_pending_d;
        end
    end

    assign {dPlus, dMinus} = line_q;
    assign OE_USB          = oe_q;
    assign txBusy          = busy_q;
    assign txDone          = done_q;

endmodule

// File: tb/tb_usb_tx_line_driver.sv
// Testbench for usb_tx_line_driver: full- and low-speed instances driven in
// parallel by a vector table, hand sequences and random packets.
module tb_usb_tx_line_driver;

    localparam int S_J   = 0;
    localparam int S_K   = 1;
    localparam int S_SE0 = 2;

    logic useClk = 1'b0;
    logic rst, checkData, txEnable, txBit, callEop;
    logic stall_fs, dp_fs, dm_fs, oe_fs, busy_fs, done_fs;
    logic stall_ls, dp_ls, dm_ls, oe_ls, busy_ls, done_ls;

    int tests = 0;
    int fails = 0;

    logic       s_stall, s_oe, s_busy, s_done, h_done;
    logic [1:0] s_line_fs, s_line_ls, h_line_fs;

    always #5 useClk = ~useClk;

    usb_tx_line_driver #(.LOW_SPEED(1'b0), .STUFF_LIMIT(6)) dut_fs (
        .useClk(useClk), .rst(rst), .checkData(checkData), .txEnable(txEnable),
        .txBit(txBit), .callEop(callEop), .txStall(stall_fs), .dPlus(dp_fs),
        .dMinus(dm_fs), .OE_USB(oe_fs), .txBusy(busy_fs), .txDone(done_fs)
    );

    usb_tx_line_driver #(.LOW_SPEED(1'b1), .STUFF_LIMIT(6)) dut_ls (
        .useClk(useClk), .rst(rst), .checkData(checkData), .txEnable(txEnable),
        .txBit(txBit), .callEop(callEop), .txStall(stall_ls), .dPlus(dp_ls),
        .dMinus(dm_ls), .OE_USB(oe_ls), .txBusy(busy_ls), .txDone(done_ls)
    );

    typedef struct {
        logic en;
        logic bt;
        logic eop;
        int   sym;
        logic oe;
        logic busy;
        logic done;
        logic stall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic bt, input logic eop, input int sym,
                                input logic oe, input logic busy, input logic done, input logic stall);
        vec_t v;
        v.en = en; v.bt = bt; v.eop = eop; v.sym = sym;
        v.oe = oe; v.busy = busy; v.done = done; v.stall = stall;
        return v;
    endfunction

    // {dPlus, dMinus} for a symbolic line state at the given speed
    function automatic logic [1:0] map_sym(input int sym, input bit ls);
        if (sym == S_SE0) return 2'b00;
        if (sym == S_J)   return ls ? 2'b01 : 2'b10;
        return ls ? 2'b10 : 2'b01;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One bit time: strobe edge, one sampled hold edge, then idle to the next negedge slot.
    task automatic do_strobe(input logic en, input logic bt, input logic eop);
        txEnable  = en;
        txBit     = bt;
        callEop   = eop;
        checkData = 1'b1;
        s_stall   = stall_fs;
        @(posedge useClk);
        #1;
        s_line_fs = {dp_fs, dm_fs};
        s_line_ls = {dp_ls, dm_ls};
        s_oe      = oe_fs;
        s_busy    = busy_fs;
        s_done    = done_fs;
        checkData = 1'b0;
        @(posedge useClk);
        #1;
        h_line_fs = {dp_fs, dm_fs};
        h_done    = done_fs;
        repeat (3) @(negedge useClk);
    endtask

    task automatic step(input string tag, input logic en, input logic bt, input logic eop,
                        input int sym, input logic oe, input logic busy, input logic done,
                        input logic stall);
        do_strobe(en, bt, eop);
        check({tag, "_stall"},   32'(s_stall),   32'(stall));
        check({tag, "_line_fs"}, 32'(s_line_fs), 32'(map_sym(sym, 1'b0)));
        check({tag, "_line_ls"}, 32'(s_line_ls), 32'(map_sym(sym, 1'b1)));
        check({tag, "_oe"},      32'(s_oe),      32'(oe));
        check({tag, "_busy"},    32'(s_busy),    32'(busy));
        check({tag, "_done"},    32'(s_done),    32'(done));
        check({tag, "_hold"},    32'(h_line_fs), 32'(map_sym(sym, 1'b0)));
        if (done) check({tag, "_done_clr"}, 32'(h_done), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_bits[14];
        int ack_syms[14];
        int bits[$];
        int stuffed[$];
        int exp_q[$];
        int n, run, lvl, idx, stalls, nstuff, gap;
        bit abort, term;
        logic en, bt, eop;

        ack_bits = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        ack_syms = '{S_K, S_J, S_K, S_J, S_K, S_K, S_J, S_J, S_K, S_J, S_J, S_K, S_K, S_K};

        // IDLE callEop is ignored, then the ACK packet
        vecs.push_back(mk(1, 0, 1, S_J, 0, 0, 0, 0));
        for (int i = 0; i < 14; i++)
            vecs.push_back(mk(1, 1'(ack_bits[i]), 0, ack_syms[i], 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, S_SE0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, S_SE0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, S_J,   1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, S_J,   0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, S_J,   0, 0, 0, 0));
        // 0 then eight 1s: stuff on the 7th strobe
        vecs.push_back(mk(1, 0, 0, S_K, 1, 1, 0, 0));
        for (int i = 0; i < 6; i++) vecs.push_back(mk(1, 1, 0, S_K, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, S_J, 1, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, S_J, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, S_J, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, S_SE0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, S_SE0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, S_J,   1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, S_J,   0, 0, 1, 0));
        // Back-to-back packet: callEop on the stall strobe delays EOP one strobe
        vecs.push_back(mk(1, 0, 0, S_K, 1, 1, 0, 0));
        for (int i = 0; i < 6; i++) vecs.push_back(mk(1, 1, 0, S_K, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, S_J,   1, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, S_SE0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, S_SE0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, S_J,   1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, S_J,   0, 0, 1, 0));

        rst = 1'b1; checkData = 1'b0; txEnable = 1'b0; txBit = 1'b0; callEop = 1'b0;
        repeat (2) @(negedge useClk);
        check("rst_line_fs", 32'({dp_fs, dm_fs}), 32'(map_sym(S_J, 1'b0)));
        check("rst_line_ls", 32'({dp_ls, dm_ls}), 32'(map_sym(S_J, 1'b1)));
        check("rst_oe",      32'(oe_fs),    32'd0);
        check("rst_busy",    32'(busy_fs),  32'd0);
        check("rst_done",    32'(done_fs),  32'd0);
        check("rst_stall",   32'(stall_fs), 32'd0);
        rst = 1'b0;
        @(negedge useClk);

        foreach (vecs[i])
            step($sformatf("v%0d", i), vecs[i].en, vecs[i].bt, vecs[i].eop, vecs[i].sym,
                 vecs[i].oe, vecs[i].busy, vecs[i].done, vecs[i].stall);

        // Abort: txEnable drops after three data bits
        step("ab0", 1, 1, 0, S_J,   1, 1, 0, 0);
        step("ab1", 1, 0, 0, S_K,   1, 1, 0, 0);
        step("ab2", 1, 1, 0, S_K,   1, 1, 0, 0);
        step("ab3", 0, 0, 0, S_SE0, 1, 1, 0, 0);
        step("ab4", 0, 0, 0, S_SE0, 1, 1, 0, 0);
        step("ab5", 0, 0, 0, S_J,   1, 1, 0, 0);
        step("ab6", 0, 0, 0, S_J,   0, 0, 1, 0);

        // Async reset in EOP_SE0 while five 1s are still counted
        step("rs0", 1, 0, 0, S_K, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) step("rs1", 1, 1, 0, S_K, 1, 1, 0, 0);
        step("rs2", 1, 0, 1, S_SE0, 1, 1, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("rs_line_fs", 32'({dp_fs, dm_fs}), 32'(map_sym(S_J, 1'b0)));
        check("rs_line_ls", 32'({dp_ls, dm_ls}), 32'(map_sym(S_J, 1'b1)));
        check("rs_oe",      32'(oe_fs),   32'd0);
        check("rs_busy",    32'(busy_fs), 32'd0);
        @(negedge useClk);
        rst = 1'b0;
        @(negedge useClk);
        for (int i = 0; i < 6; i++) step("rs3", 1, 1, 0, S_J, 1, 1, 0, 0);
        step("rs4", 1, 1, 0, S_K,   1, 1, 0, 1);
        step("rs5", 1, 0, 1, S_SE0, 1, 1, 0, 0);
        step("rs6", 0, 0, 0, S_SE0, 1, 1, 0, 0);
        step("rs7", 0, 0, 0, S_J,   1, 1, 0, 0);
        step("rs8", 0, 0, 0, S_J,   0, 0, 1, 0);

        // Random packets against a stream-level model: stuff, NRZI, then SE0 SE0 J
        for (int p = 0; p < 40; p++) begin
            n     = $urandom_range(1, 40);
            abort = ($urandom_range(0, 3) == 0);
            bits.delete(); stuffed.delete(); exp_q.delete();
            for (int i = 0; i < n; i++) bits.push_back(($urandom_range(0, 3) != 0) ? 1 : 0);
            run = 0; nstuff = 0;
            foreach (bits[i]) begin
                stuffed.push_back(bits[i]);
                run = bits[i] ? run + 1 : 0;
                if (run == 6) begin
                    stuffed.push_back(0);
                    nstuff++;
                    run = 0;
                end
            end
            lvl = S_J;
            foreach (stuffed[i]) begin
                if (stuffed[i] == 0) lvl = (lvl == S_J) ? S_K : S_J;
                exp_q.push_back(lvl);
            end
            exp_q.push_back(S_SE0); exp_q.push_back(S_SE0);
            exp_q.push_back(S_J);   exp_q.push_back(S_J);

            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++)
                step("rnd_idle", 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     S_J, 0, 0, 0, 0);

            idx = 0; stalls = 0; term = 0;
            for (int k = 0; k < exp_q.size(); k++) begin
                if (idx < n) begin
                    en = 1'b1; bt = 1'(bits[idx]); eop = 1'b0;
                end else if (!term) begin
                    en = !abort; bt = 1'($urandom_range(0, 1)); eop = !abort; term = 1;
                end else begin
                    en = 1'b0; bt = 1'b0; eop = 1'b0;
                end
                do_strobe(en, bt, eop);
                if (s_stall) stalls++;
                else if (idx < n) idx++;
                check($sformatf("rnd%0d_line_fs_%0d", p, k), 32'(s_line_fs), 32'(map_sym(exp_q[k], 1'b0)));
                check($sformatf("rnd%0d_line_ls_%0d", p, k), 32'(s_line_ls), 32'(map_sym(exp_q[k], 1'b1)));
                check($sformatf("rnd%0d_oe_%0d", p, k), 32'(s_oe), 32'(k != exp_q.size() - 1));
                check($sformatf("rnd%0d_done_%0d", p, k), 32'(s_done), 32'(k == exp_q.size() - 1));
            end
            check($sformatf("rnd%0d_stuffs", p),   32'(stalls), 32'(nstuff));
            check($sformatf("rnd%0d_consumed", p), 32'(idx),    32'(n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
